// File: rtl/sao_stat_bo_accum.sv
// rtl/sao_stat_bo_accum.sv - SAO band-offset statistics accumulator (4 bands from the chosen band position)
module sao_stat_bo_accum #(
  parameter int bit_depth = 8,
  parameter int n_pix     = 4,
  parameter int sum_w     = 22,
  parameter int cnt_w     = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_o,
  input  logic                       start,
  input  logic [1:0]                 cIdx,
  input  logic [14:0]                cand_bo,
  input  logic                       pix_valid,
  input  logic                       last,
  input  logic [bit_depth*n_pix-1:0] n_rec_m,
  input  logic [bit_depth*n_pix-1:0] n_org_m,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [1:0]                 out_cIdx,
  output logic [4:0]                 out_band,
  output logic [sum_w*4-1:0]         bo_sum,
  output logic [cnt_w*4-1:0]         bo_cnt,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t state;
  state_t state_nxt;

  logic accept;
  logic [4:0] sel_band;

  // Stage-1 pipeline: per-pixel band offset, hit flag and signed difference.
  logic                        s1_valid;
  logic [1:0]                  s1_k    [n_pix];
  logic [n_pix-1:0]            s1_hit;
  logic signed [bit_depth:0]   s1_diff [n_pix];

  // Stage-1 combinational results for the beat currently presented.
  logic [1:0]                  c_k     [n_pix];
  logic [n_pix-1:0]            c_hit;
  logic signed [bit_depth:0]   c_diff  [n_pix];

  // Stage-2 per-band increments for this beat.
  logic [sum_w-1:0]            sum_inc [4];
  logic [cnt_w-1:0]            cnt_inc [4];

  assign accept = (state == ACCUM) && en_o && pix_valid;

  // Pick the band position for the requested component (cIdx 3 is not a real component).
  always_comb begin
    sel_band = cand_bo[4:0];
    case (cIdx)
      2'd1:    sel_band = cand_bo[9:5];
      2'd2:    sel_band = cand_bo[14:10];
      default: sel_band = cand_bo[4:0];
    endcase
  end

  // Classify each pixel: 5-bit wrapped distance from out_band, hit when within the 4-band window.
  always_comb begin
    for (int i = 0; i < n_pix; i++) begin
      logic [bit_depth-1:0] rec_px;
      logic [bit_depth-1:0] org_px;
      logic [4:0]           k5;
      rec_px    = n_rec_m[i*bit_depth +: bit_depth];
      org_px    = n_org_m[i*bit_depth +: bit_depth];
      k5        = rec_px[bit_depth-1 -: 5] - out_band;
      c_k[i]    = k5[1:0];
      c_hit[i]  = (k5[4:2] == 3'd0);
      c_diff[i] = $signed({1'b0, org_px}) - $signed({1'b0, rec_px});
    end
  end

  // Sum up every hitting pixel per band; several pixels may share a band in one beat.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sum_inc[k] = '0;
      cnt_inc[k] = '0;
      for (int i = 0; i < n_pix; i++) begin
        if (s1_hit[i] && (s1_k[i] == 2'(k))) begin
          sum_inc[k] = sum_inc[k] + {{(sum_w-bit_depth-1){s1_diff[i][bit_depth]}}, s1_diff[i]};
          cnt_inc[k] = cnt_inc[k] + cnt_w'(1);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; en_o gates progress in ACCUM/DRAIN, the OUT handshake ignores it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)           state_nxt = ACCUM;
      ACCUM:   if (accept && last)  state_nxt = DRAIN;
      DRAIN:   if (en_o)            state_nxt = OUT;
      OUT:     if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  // Run setup, stage-1 capture and stage-2 accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cIdx <= '0;
      out_band <= '0;
      bo_sum   <= '0;
      bo_cnt   <= '0;
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      for (int i = 0; i < n_pix; i++) begin
        s1_k[i]    <= '0;
        s1_diff[i] <= '0;
      end
    end else if ((state == IDLE) && start) begin
      out_cIdx <= cIdx;
      out_band <= sel_band;
      bo_sum   <= '0;
      bo_cnt   <= '0;
      s1_valid <= 1'b0;
    end else if (en_o && ((state == ACCUM) || (state == DRAIN))) begin
      s1_valid <= accept;
      if (accept) begin
        s1_hit <= c_hit;
        for (int i = 0; i < n_pix; i++) begin
          s1_k[i]    <= c_k[i];
          s1_diff[i] <= c_diff[i];
        end
      end
      if (s1_valid) begin
        for (int k = 0; k < 4; k++) begin
          bo_sum[k*sum_w +: sum_w] <= bo_sum[k*sum_w +: sum_w] + sum_inc[k];
          bo_cnt[k*cnt_w +: cnt_w] <= bo_cnt[k*cnt_w +: cnt_w] + cnt_inc[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_sao_stat_bo_accum.sv
// tb/tb_sao_stat_bo_accum.sv - randomized self-checking bench for sao_stat_bo_accum
module tb_sao_stat_bo_accum;

  localparam int BD = 8;
  localparam int NP = 4;
  localparam int SW = 22;
  localparam int CW = 13;

  typedef int pix4_t [4];

  logic           clk;
  logic           rst;
  logic           en_o;
  logic           start;
  logic [1:0]     cIdx;
  logic [14:0]    cand_bo;
  logic           pix_valid;
  logic           last;
  logic [BD*NP-1:0] n_rec_m;
  logic [BD*NP-1:0] n_org_m;
  logic           out_ready;
  logic           out_valid;
  logic [1:0]     out_cIdx;
  logic [4:0]     out_band;
  logic [SW*4-1:0] bo_sum;
  logic [CW*4-1:0] bo_cnt;
  logic           busy;

  sao_stat_bo_accum #(.bit_depth(BD), .n_pix(NP), .sum_w(SW), .cnt_w(CW)) dut (
    .clk(clk), .rst(rst), .en_o(en_o), .start(start), .cIdx(cIdx), .cand_bo(cand_bo),
    .pix_valid(pix_valid), .last(last), .n_rec_m(n_rec_m), .n_org_m(n_org_m),
    .out_ready(out_ready), .out_valid(out_valid), .out_cIdx(out_cIdx), .out_band(out_band),
    .bo_sum(bo_sum), .bo_cnt(bo_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  pix4_t rec_q[$];
  pix4_t org_q[$];
  int    exp_sum [4];
  int    exp_cnt [4];
  int    exp_band;
  int    exp_cidx;
  bit    exp_armed;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int dsum(input int k);
    logic signed [SW-1:0] s;
    s = bo_sum[k*SW +: SW];
    return int'(s);
  endfunction

  function automatic int dcnt(input int k);
    return int'(bo_cnt[k*CW +: CW]);
  endfunction

  function automatic logic [31:0] pack(input pix4_t p);
    logic [31:0] r;
    int v;
    for (int i = 0; i < 4; i++) begin
      v = p[i];
      r[i*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  // Reference: every pixel falls in band rec/8; it counts toward slot (band-bo) mod 32 if that is < 4.
  function automatic void build_expect(input int bo);
    int band;
    int k;
    for (int j = 0; j < 4; j++) begin
      exp_sum[j] = 0;
      exp_cnt[j] = 0;
    end
    for (int b = 0; b < rec_q.size(); b++) begin
      for (int i = 0; i < 4; i++) begin
        band = rec_q[b][i] / (1 << (BD - 5));
        k    = (band - bo + 32) % 32;
        if (k < 4) begin
          exp_sum[k] += org_q[b][i] - rec_q[b][i];
          exp_cnt[k] += 1;
        end
      end
    end
  endfunction

  function automatic void add_beat(input pix4_t r, input pix4_t o);
    rec_q.push_back(r);
    org_q.push_back(o);
  endfunction

  // Output checker: whenever results are presented they must equal the model, every cycle.
  always @(negedge clk) begin
    if (out_valid && exp_armed) begin
      check("out_band", int'(out_band), exp_band);
      check("out_cIdx", int'(out_cIdx), exp_cidx);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("bo_sum[%0d]", k), dsum(k), exp_sum[k]);
        check($sformatf("bo_cnt[%0d]", k), dcnt(k), exp_cnt[k]);
      end
    end
  end

  task automatic run(input int cidx, input int bo, input int stall_at, input int hold, input bit gaps);
    logic [14:0] cb;
    int n;
    cb = 15'($urandom);
    cb[cidx*5 +: 5] = 5'(bo);
    cand_bo = cb;
    cIdx    = 2'(cidx);
    build_expect(bo);
    exp_band = bo;
    exp_cidx = cidx;
    n = rec_q.size();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cand_bo = 15'($urandom);
    cIdx = 2'($urandom);
    exp_armed = 1'b1;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        pix_valid = 1'b0;
        last      = 1'b1;
        n_rec_m   = $urandom;
        n_org_m   = $urandom;
        @(posedge clk); #1;
      end
      pix_valid = 1'b1;
      n_rec_m   = pack(rec_q[i]);
      n_org_m   = pack(org_q[i]);
      last      = (i == n - 1);
      if (i == stall_at) begin
        en_o = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en_o = 1'b1;
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    last      = 1'b0;
    check("latency_edge1_valid", out_valid, 0);
    @(posedge clk); #1;
    check("latency_edge2_valid", out_valid, 1);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      cIdx  = 2'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_armed = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_busy", busy, 0);
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_armed = 1'b0;
    rst = 1'b1; en_o = 1'b1; start = 1'b0; cIdx = 2'd0; cand_bo = '0;
    pix_valid = 1'b0; last = 1'b0; n_rec_m = '0; n_org_m = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_band", int'(out_band), 0);
    check("reset_cidx", int'(out_cIdx), 0);
    for (int k = 0; k < 4; k++) begin
      check("reset_sum", dsum(k), 0);
      check("reset_cnt", dcnt(k), 0);
    end

    // Basic single-beat component.
    rec_q.delete(); org_q.delete();
    add_beat('{80, 88, 96, 104}, '{82, 87, 100, 104});
    run(0, 10, -1, 0, 1'b0);
    check("basic_band", int'(out_band), 10);
    check("basic_s0", dsum(0), 2);
    check("basic_s1", dsum(1), -1);
    check("basic_s2", dsum(2), 4);
    check("basic_s3", dsum(3), 0);
    check("basic_c0", dcnt(0), 1);
    check("basic_c3", dcnt(3), 1);

    // Reset mid-run aborts with nothing left behind.
    cand_bo = 15'h7fff; cIdx = 2'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      pix_valid = 1'b1; last = 1'b0;
      n_rec_m = 32'hf8f8f8f8; n_org_m = 32'h00000000;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      check("midrst_sum", dsum(k), 0);
      check("midrst_cnt", dcnt(k), 0);
    end

    // Same-band collision plus an out-of-window pixel, two beats.
    rec_q.delete(); org_q.delete();
    add_beat('{80, 81, 82, 200}, '{85, 85, 85, 0});
    add_beat('{80, 81, 82, 200}, '{85, 85, 85, 0});
    run(0, 10, -1, 0, 1'b0);
    check("coll_s0", dsum(0), 24);
    check("coll_c0", dcnt(0), 6);
    check("coll_s1", dsum(1), 0);
    check("coll_c1", dcnt(1), 0);

    // Window wrapping past band 31.
    rec_q.delete(); org_q.delete();
    add_beat('{240, 248, 0, 8}, '{241, 249, 1, 9});
    run(2, 30, -1, 0, 1'b0);
    check("wrap_cidx", int'(out_cIdx), 2);
    for (int k = 0; k < 4; k++) begin
      check("wrap_sum", dsum(k), 1);
      check("wrap_cnt", dcnt(k), 1);
    end

    // Stall mid-stream and backpressure in OUT, start pulse during OUT.
    rec_q.delete(); org_q.delete();
    for (int b = 0; b < 6; b++) add_beat('{80, 88, 96, 104}, '{82, 87, 100, 104});
    run(1, 10, 3, 5, 1'b0);
    check("stall_s0", dsum(0), 12);
    check("stall_s1", dsum(1), -6);
    check("stall_c2", dcnt(2), 6);

    // Full 64x64 CTB.
    rec_q.delete(); org_q.delete();
    for (int b = 0; b < 1024; b++) add_beat('{128, 128, 128, 128}, '{127, 127, 127, 127});
    run(0, 16, -1, 1, 1'b0);
    check("ctb_s0", dsum(0), -4096);
    check("ctb_c0", dcnt(0), 4096);

    // Randomized components.
    for (int r = 0; r < 10; r++) begin
      int bo;
      int nb;
      pix4_t rr;
      pix4_t oo;
      bo = $urandom_range(0, 31);
      nb = $urandom_range(1, 24);
      rec_q.delete(); org_q.delete();
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 2) != 0)
            rr[i] = ((bo + $urandom_range(0, 5)) % 32) * 8 + $urandom_range(0, 7);
          else
            rr[i] = $urandom_range(0, 255);
          oo[i] = $urandom_range(0, 255);
        end
        add_beat(rr, oo);
      end
      run($urandom_range(0, 2), bo, (r % 2 == 0) ? $urandom_range(0, nb - 1) : -1,
          $urandom_range(0, 4), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sao_stat_bo_accum.md
Name: sao_stat_bo_accum

Overview:
- Band-offset statistics accumulator, directly downstream of the BO band-position reduce stage.
- For one CTB colour component, takes the selected band position cand_bo[cIdx] and streams reconstructed/original pixel beats (n_pix per beat).
- Accumulates (org − rec) sums and pixel counts for the 4 consecutive bands starting at that position.
- Presents the 4 sum/count pairs to the BO offset-decision stage over a valid/ready handshake.

Parameters:
- bit_depth, 8, sample bit width.
- n_pix, 4, pixels per input beat.
- sum_w, 22, signed width of each band sum (covers 64x64 CTB × ±(2^bit_depth−1) with margin).
- cnt_w, 13, unsigned width of each band count (max 4096).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en_o  in  1  stage enable; when 0, input acceptance and the pipeline freeze.
- start  in  1  pulse: begin a component (sampled only in IDLE).
- cIdx  in  2  component index for this run (0 = Y, 1 = Cb, 2 = Cr).
- cand_bo  in  5×3  band-position candidates from the reduce stage, indexed by cIdx.
- pix_valid  in  1  beat valid.
- last  in  1  marks the final beat of the component; qualified by pix_valid.
- n_rec_m  in  bit_depth×n_pix  reconstructed samples.
- n_org_m  in  bit_depth×n_pix  original samples.
- out_ready  in  1  downstream accept.
- out_valid  out  1  results valid.
- out_cIdx  out  2  component of the results.
- out_band  out  5  band position used.
- bo_sum  out  sum_w×4  signed sums for bands out_band+k, k = 0..3.
- bo_cnt  out  cnt_w×4  pixel counts for bands out_band+k.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Synchronous active-high reset: state = IDLE. All outputs, accumulators and pipeline registers clear to 0, so out_valid = 0, busy = 0, bo_sum/bo_cnt/out_band/out_cIdx = 0. Reset mid-run aborts the run with no output.
- FSM states: IDLE, ACCUM, DRAIN, OUT.
- IDLE:
  - start = 1 → latch out_cIdx = cIdx, out_band = cand_bo[cIdx]; clear all sums/counts; go to ACCUM.
  - start is ignored in every other state.
  - pix_valid is ignored outside ACCUM.
- ACCUM:
  - A beat is accepted when en_o && pix_valid.
  - Stage 1 (registered at the accept edge), per pixel i:
    - band_i = n_rec_m[i] >> (bit_depth−5);
    - k_i = (band_i − out_band) mod 32 (5-bit wrap);
    - hit_i = (k_i < 4);
    - diff_i = n_org_m[i] − n_rec_m[i], signed bit_depth+1.
  - Stage 2 (next en_o edge), for each k:
    - bo_sum[k] += Σ diff_i over pixels with hit_i && k_i == k;
    - bo_cnt[k] += the number of such pixels (0..n_pix).
    - Multiple pixels landing in the same band in one beat must all be counted.
  - Accepted beat with last = 1 → go to DRAIN.
- DRAIN: the stage-2 update of the last beat occurs on the next en_o edge; the state moves to OUT on that same edge.
- Latency: out_valid rises 2 en_o-qualified edges after the last beat is accepted.
- OUT:
  - out_valid = 1; all outputs are held stable until out_valid && out_ready, which is sampled every clk regardless of en_o.
  - On handshake → IDLE; out_valid drops the next cycle.
- en_o = 0 freezes the FSM in ACCUM/DRAIN and all pipeline/accumulator registers; a beat presented while en_o = 0 is not accepted.
- Wrap-around: out_band = 30 covers bands 30, 31, 0, 1. Pixels in bands 2..29 are excluded.
- Sums do not saturate; sum_w is sized so overflow cannot occur for a ≤4096-pixel component.
- A single-beat component (last on the first accepted beat) is legal.

Test Plan:
- Reset/idle: assert rst mid-ACCUM → next cycle state IDLE, out_valid = 0, busy = 0, all sums/counts 0; a following run produces only that run's data.
- Basic accumulation: cIdx = 0, cand_bo[0] = 10, one beat rec = {80,88,96,104}, org = {82,87,100,104}, last = 1 → out_band = 10, bo_sum = {2,−1,4,0}, bo_cnt = {1,1,1,1}, out_valid rises 2 edges after the beat.
- Same-band collision and exclusion: cand_bo = 10, rec = {80,81,82,200}, org = {85,85,85,0}, over two beats (second beat identical, last) → bo_sum[0] = 24, bo_cnt[0] = 6, all other sums/counts 0.
- Wrap: cIdx = 2, cand_bo[2] = 30, rec = {240,248,0,8}, org = rec + 1 → bo_sum = {1,1,1,1}, bo_cnt = {1,1,1,1}, out_cIdx = 2.
- Stall/backpressure: toggle en_o low for 3 cycles mid-stream with pix_valid held high, and hold out_ready = 0 for 5 cycles in OUT → totals equal the no-stall run; outputs stay stable until out_ready; IDLE one cycle after the handshake; a start pulse during OUT is ignored.
- Full CTB: 1024 beats of rec = 128, org = 127, cand_bo = 16 → bo_sum[0] = −4096, bo_cnt[0] = 4096, no overflow.
